alu_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU.
- Adds WIDTH generality, XOR and arithmetic-right-shift ops, and an iterative one-bit-per-cycle shifter.
- valid/ready handshakes on input and output; result and flags are registered.
- Sits between the operand/decoder front end and the result writeback/flag register.

---
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and an iterative one-bit-per-cycle shifter.
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   s_amt,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    state_t           state, state_next;
    logic [WIDTH-1:0] result_q, result_next;
    logic [WIDTH-1:0] work_q, work_next;
    logic [SHW-1:0]   count_q, count_next;
    logic [2:0]       sop_q, sop_next;
    logic             carry_q, carry_next;
    logic             ovf_q, ovf_next;
    logic             zero_q, neg_q;
    logic             write_res;

    logic             accept, is_shift, is_sub;
    logic [WIDTH-1:0] b_eff, arith_res, step;
    logic [WIDTH:0]   sum;
    logic             arith_ovf, step_out;

    assign in_ready  = ~rst & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign is_shift  = (op == OP_SLL) | (op == OP_SRL) | (op == OP_SRA);
    assign is_sub    = (op == OP_SUB);
    assign b_eff     = is_sub ? ~b : b;
    assign sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign arith_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_SAT_EN
    // On overflow the true result has the sign of a, so clamp toward that end.
    assign arith_res = !arith_ovf  ? sum[WIDTH-1:0] :
                       a[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign arith_res = sum[WIDTH-1:0];
`endif

    always_comb begin
        step     = work_q;
        step_out = 1'b0;
        case (sop_q)
            OP_SLL: begin
                step     = {work_q[WIDTH-2:0], 1'b0};
                step_out = work_q[WIDTH-1];
            end
            OP_SRL: begin
                step     = {1'b0, work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            OP_SRA: begin
                step     = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next  = state;
        result_next = result_q;
        carry_next  = carry_q;
        ovf_next    = ovf_q;
        work_next   = work_q;
        count_next  = count_q;
        sop_next    = sop_q;
        write_res   = 1'b0;
        case (state)
            SHIFT: begin
                work_next  = step;
                count_next = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    result_next = step;
                    carry_next  = step_out;
                    ovf_next    = 1'b0;
                    write_res   = 1'b1;
                    state_next  = HOLD;
                end
            end
            default: begin
                if ((state == HOLD) && out_ready)
                    state_next = IDLE;
                if (accept) begin
                    if (is_shift) begin
                        work_next  = a;
                        count_next = s_amt;
                        sop_next   = op;
                        if (s_amt == '0) begin
                            result_next = a;
                            carry_next  = 1'b0;
                            ovf_next    = 1'b0;
                            write_res   = 1'b1;
                            state_next  = HOLD;
                        end else begin
                            state_next = SHIFT;
                        end
                    end else begin
                        write_res  = 1'b1;
                        state_next = HOLD;
                        carry_next = 1'b0;
                        ovf_next   = 1'b0;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                result_next = arith_res;
                                carry_next  = sum[WIDTH];
                                ovf_next    = arith_ovf;
                            end
                            OP_AND:  result_next = a & b;
                            OP_OR:   result_next = a | b;
                            OP_XOR:  result_next = a ^ b;
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // zero/negative only follow a freshly written result so reset leaves them clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            work_q   <= '0;
            count_q  <= '0;
            sop_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            result_q <= result_next;
            work_q   <= work_next;
            count_q  <= count_next;
            sop_q    <= sop_next;
            carry_q  <= carry_next;
            ovf_q    <= ovf_next;
            if (write_res) begin
                zero_q <= (result_next == '0);
                neg_q  <= result_next[WIDTH-1];
            end
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign out_valid = (state == HOLD);
    assign busy      = (state == SHIFT);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a vector table fed through a result scoreboard,
// followed by backpressure, reset-mid-shift and busy-input corner sequences.
module tb_alu_seq;
    localparam int WIDTH = 8;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SLL = 3'b101, SRL = 3'b110, SRA = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] s_amt = 3'd0;
    logic [2:0] op = 3'd0;
    logic       in_ready, out_valid, zero, negative, carry, overflow, busy;
    logic [7:0] result;

    typedef struct {
        int         id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] s_amt;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[19];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s_amt(s_amt), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input int id, input logic [2:0] o, input logic [7:0] va,
                                input logic [7:0] vb, input logic [2:0] sa, input logic [7:0] r,
                                input logic c, input logic v);
        vec_t t;
        t.id = id; t.op = o; t.a = va; t.b = vb; t.s_amt = sa; t.res = r; t.c = c; t.v = v;
        return t;
    endfunction

    // Scoreboard: every completed output handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        vec_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("v%0d_result", e.id), result, e.res);
                checkOutput($sformatf("v%0d_zero", e.id), zero, (e.res == 8'h00));
                checkOutput($sformatf("v%0d_negative", e.id), negative, e.res[7]);
                checkOutput($sformatf("v%0d_carry", e.id), carry, e.c);
                checkOutput($sformatf("v%0d_overflow", e.id), overflow, e.v);
            end
        end
    end

    // Drives an op and waits for it to be accepted; returns just after the accept edge.
    task automatic issueOp(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                           input logic [2:0] sa, output bit ok);
        int w = 0;
        in_valid = 1'b1; op = o; a = va; b = vb; s_amt = sa;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        ok = in_ready;
        if (!ok) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bit ok;
        int lat = 0;
        int bsy = 0;
        int exp_lat;
        exp_lat = (v.op >= SLL) ? 1 + int'(v.s_amt) : 1;
        exp_q.push_back(v);
        issueOp(v.op, v.a, v.b, v.s_amt, ok);
        if (ok) begin
            do begin
                @(negedge clk);
                lat++;
                if (busy) bsy++;
            end while (!out_valid && lat < 50);
            checkOutput($sformatf("v%0d_latency", v.id), lat, exp_lat);
            checkOutput($sformatf("v%0d_busy_cycles", v.id), bsy, (v.op >= SLL) ? int'(v.s_amt) : 0);
        end
    endtask

    initial begin
        vec_t bp_vec;
        vec_t and_vec;
        vec_t sra_vec;
        bit   ok;
        int   stale;
        int   w;

`ifdef ALU_SAT_EN
        vecs[0]  = mk(0,  ADD,  8'h7F, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b1);
        vecs[4]  = mk(4,  ADD,  8'h80, 8'h80, 3'd0, 8'h80, 1'b1, 1'b1);
        vecs[5]  = mk(5,  SUB,  8'h80, 8'h01, 3'd0, 8'h80, 1'b1, 1'b1);
`else
        vecs[0]  = mk(0,  ADD,  8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1);
        vecs[4]  = mk(4,  ADD,  8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1);
        vecs[5]  = mk(5,  SUB,  8'h80, 8'h01, 3'd0, 8'h7F, 1'b1, 1'b1);
`endif
        vecs[1]  = mk(1,  SUB,  8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[2]  = mk(2,  SUB,  8'h03, 8'h05, 3'd0, 8'hFE, 1'b0, 1'b0);
        vecs[3]  = mk(3,  ADD,  8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[6]  = mk(6,  AND_, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0);
        vecs[7]  = mk(7,  OR_,  8'h0F, 8'hA0, 3'd0, 8'hAF, 1'b0, 1'b0);
        vecs[8]  = mk(8,  XOR_, 8'hAA, 8'hAA, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[9]  = mk(9,  XOR_, 8'h5A, 8'hFF, 3'd0, 8'hA5, 1'b0, 1'b0);
        vecs[10] = mk(10, SLL,  8'h81, 8'h00, 3'd1, 8'h02, 1'b1, 1'b0);
        vecs[11] = mk(11, SLL,  8'h55, 8'h00, 3'd0, 8'h55, 1'b0, 1'b0);
        vecs[12] = mk(12, SRL,  8'h81, 8'h00, 3'd1, 8'h40, 1'b1, 1'b0);
        vecs[13] = mk(13, SRA,  8'h90, 8'h00, 3'd3, 8'hF2, 1'b0, 1'b0);
        vecs[14] = mk(14, SRA,  8'h7F, 8'h00, 3'd7, 8'h00, 1'b1, 1'b0);
        vecs[15] = mk(15, SRL,  8'h80, 8'h00, 3'd7, 8'h01, 1'b0, 1'b0);
        vecs[16] = mk(16, SLL,  8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 1'b0);
        vecs[17] = mk(17, ADD,  8'h3C, 8'h0C, 3'd0, 8'h48, 1'b0, 1'b0);
        vecs[18] = mk(18, SUB,  8'h00, 8'h01, 3'd0, 8'hFF, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_result", result, 8'h00);
        checkOutput("rst_zero", zero, 1'b0);
        checkOutput("rst_negative", negative, 1'b0);
        checkOutput("rst_carry", carry, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1 checkOutput("in_ready_after_rst", in_ready, 1'b1);
        @(negedge clk);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Backpressure: hold the ADD result for 5 cycles, then release together with a new AND
        @(posedge clk); #1 out_ready = 1'b0;
        bp_vec = vecs[0];
        bp_vec.id = 100;
        applyStimulus(bp_vec);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_hold_result", result, bp_vec.res);
            checkOutput("bp_hold_overflow", overflow, 1'b1);
            checkOutput("bp_hold_valid", out_valid, 1'b1);
            checkOutput("bp_hold_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        and_vec = mk(101, AND_, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0);
        exp_q.push_back(and_vec);
        out_ready = 1'b1; in_valid = 1'b1; op = AND_; a = 8'hF0; b = 8'h3C; s_amt = 3'd0;
        @(negedge clk);
        checkOutput("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_no_bubble_valid", out_valid, 1'b1);
        checkOutput("bp_next_result", result, 8'h30);

        // Reset in the middle of a long shift discards it
        @(posedge clk); #1;
        in_valid = 1'b1; op = SLL; a = 8'h01; b = 8'h00; s_amt = 3'd7;
        @(negedge clk);
        checkOutput("rs_in_ready", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rs_busy_before", busy, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rs_out_valid", out_valid, 1'b0);
        checkOutput("rs_busy", busy, 1'b0);
        checkOutput("rs_result", result, 8'h00);
        checkOutput("rs_zero", zero, 1'b0);
        checkOutput("rs_carry", carry, 1'b0);
        checkOutput("rs_in_ready_in_rst", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("rs_in_ready_after", in_ready, 1'b1);
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("rs_no_stale_valid", stale, 0);

        // XOR presented while shifting must be ignored
        sra_vec = mk(200, SRA, 8'h90, 8'h00, 3'd3, 8'hF2, 1'b0, 1'b0);
        exp_q.push_back(sra_vec);
        issueOp(SRA, 8'h90, 8'h00, 3'd3, ok);
        in_valid = 1'b1; op = XOR_; a = 8'hAA; b = 8'h55; s_amt = 3'd0;
        @(negedge clk);
        checkOutput("busy_in_ready", in_ready, 1'b0);
        checkOutput("busy_flag", busy, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("busy_done_valid", out_valid, 1'b1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("busy_no_extra_output", stale, 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
